// File: rtl/signal_cfg_shadow_pkg.sv
// signal_cfg_pkg: shared widths, FSM state and commit-mode encodings for the config shadow store.
package signal_cfg_pkg;
   localparam int CFG_WIDTH  = 832;
   localparam int WORD_WIDTH = 32;
   localparam int NUM_WORDS  = CFG_WIDTH / WORD_WIDTH;
   localparam int ADDR_WIDTH = 5;
   localparam int STRB_WIDTH = WORD_WIDTH / 8;
   localparam int CNT_WIDTH  = 16;
   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;
   localparam logic COMMIT_NOW  = 1'b0;
   localparam logic COMMIT_SYNC = 1'b1;
endpackage

// File: rtl/signal_cfg_shadow_if.sv
// signal_cfg_shadow_if: staging write, commit control, readback and active-config bus of the shadow store.
interface signal_cfg_shadow_if;
   import signal_cfg_pkg::*;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WORD_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic                  commit_req;
   logic                  commit_mode;
   logic                  sync_in;
   logic                  abort;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_sel;
   logic [WORD_WIDTH-1:0] rd_data;
   logic [CFG_WIDTH-1:0]  cfg_data;
   logic                  cfg_update;
   logic                  pending;
   logic                  wr_err;
   logic [CNT_WIDTH-1:0]  commit_count;
   modport slave (
      input  wr_en, wr_addr, wr_data, wr_strb, commit_req, commit_mode, sync_in, abort, rd_addr, rd_sel,
      output rd_data, cfg_data, cfg_update, pending, wr_err, commit_count
   );
   modport master (
      output wr_en, wr_addr, wr_data, wr_strb, commit_req, commit_mode, sync_in, abort, rd_addr, rd_sel,
      input  rd_data, cfg_data, cfg_update, pending, wr_err, commit_count
   );
endinterface

// File: rtl/signal_cfg_shadow.sv
// signal_cfg_shadow: double-buffered config store; staging copy moves atomically to cfg_data
// either immediately or at the next waveform period boundary.
module signal_cfg_shadow
   import signal_cfg_pkg::*;
(
   input logic                aclk,
   input logic                aresetn,
   signal_cfg_shadow_if.slave bus
);
   state_t                state_q, state_d;
   logic [CFG_WIDTH-1:0]  stage_q, stage_d, active_q, active_d;
   logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [CNT_WIDTH-1:0]  commit_count_q, commit_count_d;
   logic                  cfg_update_q, cfg_update_d;
   logic                  pending_q, pending_d;
   logic                  wr_err_q, wr_err_d;
   logic                  wr_ok, copy_now, req_now;

   assign wr_ok   = bus.wr_en && (bus.wr_addr < ADDR_WIDTH'(NUM_WORDS));
   assign req_now = bus.commit_req && (bus.commit_mode == COMMIT_NOW);

   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
      for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_byte
         assign stage_d[k*WORD_WIDTH + b*8 +: 8] =
            (wr_ok && bus.wr_addr == ADDR_WIDTH'(k) && bus.wr_strb[b]) ? bus.wr_data[b*8 +: 8]
                                                                      : stage_q[k*WORD_WIDTH + b*8 +: 8];
      end
   end

   // abort outranks everything while armed; sync_in only counts once armed
   always_comb begin
      copy_now = (state_q == IDLE) ? req_now : (!bus.abort && (req_now || bus.sync_in));
      state_d  = (state_q == IDLE) ? ((bus.commit_req && bus.commit_mode == COMMIT_SYNC) ? ARMED : IDLE)
                                   : ((bus.abort || copy_now) ? IDLE : ARMED);
      active_d       = copy_now ? stage_q : active_q;
      commit_count_d = commit_count_q + CNT_WIDTH'(copy_now);
      cfg_update_d   = copy_now;
      pending_d      = (state_d == ARMED);
      wr_err_d       = bus.wr_en && !wr_ok;
      rd_data_d      = '0;
      for (int k = 0; k < NUM_WORDS; k++)
         if (bus.rd_addr == ADDR_WIDTH'(k))
            rd_data_d = bus.rd_sel ? active_q[k*WORD_WIDTH +: WORD_WIDTH] : stage_q[k*WORD_WIDTH +: WORD_WIDTH];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q        <= IDLE;
         stage_q        <= '0;
         active_q       <= '0;
         rd_data_q      <= '0;
         commit_count_q <= '0;
         cfg_update_q   <= 1'b0;
         pending_q      <= 1'b0;
         wr_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         stage_q        <= stage_d;
         active_q       <= active_d;
         rd_data_q      <= rd_data_d;
         commit_count_q <= commit_count_d;
         cfg_update_q   <= cfg_update_d;
         pending_q      <= pending_d;
         wr_err_q       <= wr_err_d;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.cfg_data     = active_q;
   assign bus.commit_count = commit_count_q;
   assign bus.cfg_update   = cfg_update_q;
   assign bus.pending      = pending_q;
   assign bus.wr_err       = wr_err_q;
endmodule

// File: tb/tb_signal_cfg_shadow.sv
// tb_signal_cfg_shadow: directed checks of staging writes, immediate/synced commits, abort, readback and wrap.
module tb_signal_cfg_shadow;
   import signal_cfg_pkg::*;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   int total = 0;
   int bad = 0;
   int exp_cnt = 0;
   logic [31:0] rd;

   signal_cfg_shadow_if bus();
   signal_cfg_shadow dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_strb = 0;
      bus.commit_req = 0; bus.commit_mode = 0; bus.sync_in = 0; bus.abort = 0;
   endtask

   task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
      step();
      bus.wr_en = 0;
   endtask

   task automatic read_word(input logic sel, input logic [4:0] a, output logic [31:0] d);
      bus.rd_sel = sel; bus.rd_addr = a;
      step();
      d = bus.rd_data;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.rd_sel = 1; bus.rd_addr = 0;
      aresetn = 0;
      step(); step();
      aresetn = 1;
      step();
      total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
      total++; if (bus.cfg_data !== '0) begin bad++; $display("FAIL reset_cfg_data got=%h want=0", bus.cfg_data[31:0]); end
      total++; if (bus.commit_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.commit_count); end
      total++; if ({bus.pending, bus.cfg_update, bus.wr_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.pending, bus.cfg_update, bus.wr_err}); end
   endtask

   task automatic test_immediate();
      write_word(5'd1, 32'h1234_0000, 4'hF);
      bus.commit_req = 1; bus.commit_mode = COMMIT_NOW;
      step();
      bus.commit_req = 0;
      exp_cnt++;
      total++; if (bus.cfg_data[63:48] !== 16'h1234) begin bad++; $display("FAIL imm_cfg got=%h want=1234", bus.cfg_data[63:48]); end
      total++; if (bus.cfg_update !== 1'b1) begin bad++; $display("FAIL imm_update got=%b want=1", bus.cfg_update); end
      total++; if (bus.commit_count !== 16'(exp_cnt)) begin bad++; $display("FAIL imm_count got=%0d want=%0d", bus.commit_count, exp_cnt); end
      step();
      total++; if (bus.cfg_update !== 1'b0) begin bad++; $display("FAIL imm_update_pulse got=%b want=0", bus.cfg_update); end
   endtask

   task automatic test_byte_enables();
      write_word(5'd0, 32'hAABB_CCDD, 4'h5);
      read_word(1'b0, 5'd0, rd);
      total++; if (rd !== 32'h00BB_00DD) begin bad++; $display("FAIL strb_stage got=%h want=00bb00dd", rd); end
      read_word(1'b1, 5'd0, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL strb_active got=%h want=0", rd); end
   endtask

   task automatic test_synced();
      bus.commit_req = 1; bus.commit_mode = COMMIT_SYNC; bus.sync_in = 1;
      step();
      bus.commit_req = 0; bus.sync_in = 0;
      total++; if (bus.pending !== 1'b1 || bus.cfg_update !== 1'b0) begin bad++; $display("FAIL sync_arm got=%b%b want=10", bus.pending, bus.cfg_update); end
      write_word(5'd2, 32'h0000_0055, 4'hF);
      step(); step();
      total++; if (bus.cfg_data[95:64] !== 32'h0 || bus.pending !== 1'b1) begin bad++; $display("FAIL sync_hold got=%h/%b want=0/1", bus.cfg_data[95:64], bus.pending); end
      bus.sync_in = 1;
      step();
      bus.sync_in = 0;
      exp_cnt++;
      total++; if (bus.cfg_data[95:64] !== 32'h55) begin bad++; $display("FAIL sync_word2 got=%h want=55", bus.cfg_data[95:64]); end
      total++; if (bus.cfg_data[31:0] !== 32'h00BB_00DD) begin bad++; $display("FAIL sync_word0 got=%h want=00bb00dd", bus.cfg_data[31:0]); end
      total++; if (bus.cfg_update !== 1'b1 || bus.pending !== 1'b0) begin bad++; $display("FAIL sync_flags got=%b%b want=10", bus.cfg_update, bus.pending); end
      total++; if (bus.commit_count !== 16'(exp_cnt)) begin bad++; $display("FAIL sync_count got=%0d want=%0d", bus.commit_count, exp_cnt); end
   endtask

   task automatic test_abort();
      bus.commit_req = 1; bus.commit_mode = COMMIT_SYNC;
      step();
      bus.commit_req = 0;
      write_word(5'd3, 32'hDEAD_BEEF, 4'hF);
      bus.abort = 1; bus.sync_in = 1;
      step();
      bus.abort = 0; bus.sync_in = 0;
      total++; if (bus.pending !== 1'b0 || bus.cfg_update !== 1'b0) begin bad++; $display("FAIL abort_flags got=%b%b want=00", bus.pending, bus.cfg_update); end
      total++; if (bus.cfg_data[127:96] !== 32'h0) begin bad++; $display("FAIL abort_word3 got=%h want=0", bus.cfg_data[127:96]); end
      total++; if (bus.commit_count !== 16'(exp_cnt)) begin bad++; $display("FAIL abort_count got=%0d want=%0d", bus.commit_count, exp_cnt); end
      bus.sync_in = 1;
      step();
      bus.sync_in = 0;
      total++; if (bus.cfg_update !== 1'b0) begin bad++; $display("FAIL abort_idle_sync got=%b want=0", bus.cfg_update); end
      bus.commit_req = 1; bus.commit_mode = COMMIT_SYNC;
      step();
      bus.commit_mode = COMMIT_NOW;
      step();
      bus.commit_req = 0;
      exp_cnt++;
      total++; if (bus.cfg_data[127:96] !== 32'hDEAD_BEEF || bus.pending !== 1'b0) begin bad++; $display("FAIL armed_now got=%h/%b want=deadbeef/0", bus.cfg_data[127:96], bus.pending); end
   endtask

   task automatic test_out_of_range();
      write_word(5'd26, 32'hFFFF_FFFF, 4'hF);
      total++; if (bus.wr_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want=1", bus.wr_err); end
      step();
      total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b want=0", bus.wr_err); end
      read_word(1'b0, 5'd26, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd got=%h want=0", rd); end
      read_word(1'b0, 5'd25, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_word25 got=%h want=0", rd); end
      read_word(1'b0, 5'd0, rd);
      total++; if (rd !== 32'h00BB_00DD) begin bad++; $display("FAIL oor_word0 got=%h want=00bb00dd", rd); end
   endtask

   task automatic test_same_cycle();
      bus.commit_req = 1; bus.commit_mode = COMMIT_NOW;
      write_word(5'd4, 32'hCAFE_0001, 4'hF);
      bus.commit_req = 0;
      exp_cnt++;
      total++; if (bus.cfg_update !== 1'b1 || bus.cfg_data[159:128] !== 32'h0) begin bad++; $display("FAIL same_active got=%b/%h want=1/0", bus.cfg_update, bus.cfg_data[159:128]); end
      read_word(1'b0, 5'd4, rd);
      total++; if (rd !== 32'hCAFE_0001) begin bad++; $display("FAIL same_stage got=%h want=cafe0001", rd); end
      read_word(1'b1, 5'd4, rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL same_rd_active got=%h want=0", rd); end
   endtask

   task automatic test_wrap();
      int n;
      n = 65536 - exp_cnt;
      bus.commit_req = 1; bus.commit_mode = COMMIT_NOW;
      for (int i = 0; i < n - 1; i++) step();
      total++; if (bus.commit_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", bus.commit_count); end
      step();
      bus.commit_req = 0;
      total++; if (bus.commit_count !== 16'h0) begin bad++; $display("FAIL wrap_zero got=%h want=0", bus.commit_count); end
   endtask

   task automatic test_reset_armed();
      bus.commit_req = 1; bus.commit_mode = COMMIT_SYNC;
      step();
      bus.commit_req = 0;
      aresetn = 0;
      step();
      aresetn = 1;
      total++; if (bus.pending !== 1'b0 || bus.cfg_data !== '0) begin bad++; $display("FAIL rst_armed got=%b/%h want=0/0", bus.pending, bus.cfg_data[31:0]); end
      bus.sync_in = 1;
      step();
      bus.sync_in = 0;
      total++; if (bus.cfg_update !== 1'b0 || bus.commit_count !== 16'h0) begin bad++; $display("FAIL rst_armed_sync got=%b/%0d want=0/0", bus.cfg_update, bus.commit_count); end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_byte_enables();
      test_synced();
      test_abort();
      test_out_of_range();
      test_same_cycle();
      test_wrap();
      test_reset_armed();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/signal_cfg_shadow.md
# signal_cfg_shadow

Double-buffered configuration store directly upstream of the per-channel signal config slicer. Software writes 32-bit words into a staging copy of the 832-bit channel configuration. A commit request transfers the staging copy atomically to the active `cfg_data` bus, either immediately or at the next waveform period boundary. The slicer and generator therefore never see a half-updated parameter set.

## Interface
- `CFG_WIDTH`, 832: width of the config vector; must be a multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 32: write/read word width.
- `NUM_WORDS`, `CFG_WIDTH/WORD_WIDTH` (26): number of addressable words.
- `ADDR_WIDTH`, 5: word address width.

Ports:
- `aclk` in 1: sole clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `wr_en` in 1: staging write strobe.
- `wr_addr` in `ADDR_WIDTH`: word index.
- `wr_data` in `WORD_WIDTH`: write data.
- `wr_strb` in `WORD_WIDTH/8`: byte enables.
- `commit_req` in 1: single-cycle commit request.
- `commit_mode` in 1: 0 = immediate, 1 = at next `sync_in`.
- `sync_in` in 1: period-boundary pulse from the waveform generator.
- `abort` in 1: cancels a pending synced commit.
- `rd_addr` in `ADDR_WIDTH`: readback word index.
- `rd_sel` in 1: 0 = staging, 1 = active.
- `rd_data` out `WORD_WIDTH`: registered readback.
- `cfg_data` out `CFG_WIDTH`: active configuration, feeds the slicer.
- `cfg_update` out 1: one-cycle pulse, asserted in the first cycle the new `cfg_data` is visible.
- `pending` out 1: high while a synced commit is armed.
- `wr_err` out 1: one-cycle pulse on an out-of-range write.
- `commit_count` out 16: number of completed commits.

## Operation
- **Word mapping:** word k occupies `cfg[32k+31:32k]`.
- **Staging writes:**
  - `wr_en` with `wr_addr < NUM_WORDS` updates each byte whose `wr_strb` bit is set.
  - Out-of-range writes are dropped; `wr_err` pulses the next cycle.
- **States:** `IDLE`, `ARMED`.
- **IDLE:**
  - `commit_req` & mode 0: copy staging to active. Stay in `IDLE`.
  - `commit_req` & mode 1: go to `ARMED`. `sync_in` in that same cycle does not count.
  - `abort` is ignored.
- **ARMED:**
  - Priority is `abort` > `commit_req` mode 0 > `sync_in`.
  - `abort`: go to `IDLE`, no update.
  - `commit_req` mode 0: copy now, go to `IDLE`.
  - `sync_in`: copy, go to `IDLE`.
  - `commit_req` mode 1: ignored, stays armed.
- **Copy semantics:**
  - The copy takes the registered staging value.
  - A write in the same cycle as the copy is not included; it remains in staging only.
  - Writes made while `ARMED`, before the sync cycle, are included.
- **Counters and flags:**
  - Every copy increments `commit_count`, which wraps 0xFFFF to 0x0000.
  - Every copy pulses `cfg_update`.
  - `pending` = (state == `ARMED`), registered.
- **Readback:** registered `rd_data` returns the selected copy of word `rd_addr`. Out-of-range addresses return 0.

## Timing
- **Reset values:** staging and `cfg_data` all-zero; `rd_data`, `commit_count` = 0; `cfg_update`, `pending`, `wr_err` = 0; state `IDLE`.
- **Reset mid-operation:** reset while `ARMED` discards the pending commit.
- **Write latency:** a write at cycle N is visible in staging at N+1, and in `rd_data` at N+2 when `rd_addr` is held.
- **Immediate commit:** `commit_req` at N → `cfg_data` new at N+1, `cfg_update` high at N+1 only.
- **Synced commit:**
  - `commit_req` at N → `pending` high at N+1.
  - First `sync_in` at M ≥ N+1 → `cfg_data` new at M+1, `cfg_update` at M+1, `pending` low at M+1.
- **Outputs:** all are registered; no combinational path from inputs to outputs.

## Structure
- **Package `signal_cfg_pkg`:** `CFG_WIDTH`, `WORD_WIDTH`, `NUM_WORDS`, the state enum (`IDLE`, `ARMED`), and the mode constants `COMMIT_NOW`/`COMMIT_SYNC`.
- **Sub-modules:** none; one flat module with a generate loop over words/bytes.

## Test plan
- **Reset readback:** after reset, read active word 0 → `rd_data`=0, `cfg_data`=0, `commit_count`=0.
- **Immediate commit:**
  - Write word 1 = 0x1234_0000 with `wr_strb`=0xF, then `commit_req` mode 0.
  - One cycle later `cfg_data[63:48]`=0x1234, `cfg_update` pulses once, `commit_count`=1.
- **Byte enables:** write word 0 = 0xAABBCCDD with strb 0x5 over 0 → staging word 0 = 0x00BB00DD.
- **Synced commit with late write:**
  - Mode 1 commit, then write word 2 = 0x55 while `ARMED`.
  - `cfg_data` unchanged until `sync_in`, new value including 0x55 one cycle after sync.
  - `pending` falls at the same time.
- **Abort priority and wrap:**
  - While `ARMED`, assert `abort` and `sync_in` together → no update, `pending`=0.
  - Separately, 65536 commits → `commit_count` wraps to 0.
- **Out-of-range write:**
  - `wr_addr`=26 → `wr_err` pulse, staging unchanged.
  - A write in the same cycle as an immediate commit is absent from `cfg_data` but present in staging readback.
